// File: rtl/seq_detector_param_if.sv
// Bus bundle for the programmable serial pattern detector: configuration, serial stream and status.
// The slave modport is the detector's view; the master modport is the view of whoever drives it.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               cfg_load_i;
  logic [MAX_LEN-1:0] cfg_pattern_i;
  logic [LEN_W-1:0]   cfg_len_i;
  logic               cfg_overlap_i;
  logic               din_valid_i;
  logic               din_i;
  logic               clr_count_i;
  logic               match_o;
  logic [CNT_W-1:0]   match_count_o;
  logic               count_sat_o;
  logic               cfg_err_o;
  logic               active_o;

  modport master (
    output cfg_load_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i,
    output din_valid_i, din_i, clr_count_i,
    input  match_o, match_count_o, count_sat_o, cfg_err_o, active_o
  );

  modport slave (
    input  cfg_load_i, cfg_pattern_i, cfg_len_i, cfg_overlap_i,
    input  din_valid_i, din_i, clr_count_i,
    output match_o, match_count_o, count_sat_o, cfg_err_o, active_o
  );
endinterface

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits, overlap selectable)
// with registered match pulse, saturating match counter and sticky config-error flag.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_param_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

  state_t             state_q;
  logic [MAX_LEN-1:0] hist_q, pattern_q;
  logic [LEN_W-1:0]   fill_q, len_q;
  logic               overlap_q;
  logic               match_q;
  logic [CNT_W-1:0]   count_q;
  logic               sat_q;
  logic               err_q;

  logic [MAX_LEN-1:0] hist_d;
  logic [LEN_W-1:0]   fill_d;
  logic [CNT_W-1:0]   count_d;
  logic [MAX_LEN-1:0] len_mask;
  logic               step;
  logic               hit;
  logic               cfg_ok;

  // Only the low len bits of history and pattern take part in the compare.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
    assign len_mask[gi] = (len_q > LEN_W'(gi));
  end

  always_comb begin
    step    = (state_q == RUN) && bus.din_valid_i && !bus.cfg_load_i;
    hist_d  = {hist_q[MAX_LEN-2:0], bus.din_i};
    fill_d  = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    hit     = step && (fill_d >= len_q) && (((hist_d ^ pattern_q) & len_mask) == '0);
    cfg_ok  = (bus.cfg_len_i != '0) && (bus.cfg_len_i <= FULL);
    count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hist_q    <= '0;
      pattern_q <= '0;
      fill_q    <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      match_q   <= 1'b0;
      count_q   <= '0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      match_q <= hit;

      if (bus.cfg_load_i) begin
        if (cfg_ok) begin
          state_q   <= RUN;
          pattern_q <= bus.cfg_pattern_i;
          len_q     <= bus.cfg_len_i;
          overlap_q <= bus.cfg_overlap_i;
          hist_q    <= '0;
          fill_q    <= '0;
        end else begin
          err_q <= 1'b1;
        end
      end else if (step) begin
        hist_q <= hist_d;
        // Non-overlap restarts the fill so the next match needs len fresh bits.
        fill_q <= (hit && !overlap_q) ? '0 : fill_d;
      end

      if (bus.clr_count_i) begin
        count_q <= '0;
        sat_q   <= 1'b0;
      end else if (hit && (count_q != '1)) begin
        count_q <= count_d;
        if (count_d == '1) begin
          sat_q <= 1'b1;
        end
      end
    end
  end

  assign bus.match_o       = match_q;
  assign bus.match_count_o = count_q;
  assign bus.count_sat_o   = sat_q;
  assign bus.cfg_err_o     = err_q;
  assign bus.active_o      = (state_q == RUN);

endmodule
